// File: rtl/red_iterativa_pkg.sv
// Shared definitions for the right-to-left iterative comparator family.
// Holds the controller state encoding and the "empty prefix is equal" seed value.
package red_iterativa_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic Z_INIT = 1'b1;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StRun  = ST_RUN,
      StDone = ST_DONE
   } state_e;

endpackage

// File: rtl/red_iterativa_serial_ctrl_if.sv
// Request/result bundle for the serial comparator; Eq exists only with
// RED_SERIAL_EQ_FLAG_EN defined.
interface red_iterativa_serial_ctrl_if #(
   parameter int unsigned N = 3
);
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         busy;
   logic         done;
   logic         Zout;
`ifdef RED_SERIAL_EQ_FLAG_EN
   logic         Eq;

   modport master (output start, A, B, input busy, done, Zout, Eq);
   modport slave  (input start, A, B, output busy, done, Zout, Eq);
`else
   modport master (output start, A, B, input busy, done, Zout);
   modport slave  (input start, A, B, output busy, done, Zout);
`endif
endinterface

// File: rtl/celda_der_izq.sv
// Single-bit right-to-left comparison cell: z_out = 1 while the prefix seen so far
// (this bit plus lower bits) still satisfies A <= B.
module celda_der_izq (
   input  logic a,
   input  logic b,
   input  logic z_in,
   output logic z_out
);
   assign z_out = (~a & b) | (~(a ^ b) & z_in);
endmodule

// File: rtl/red_iterativa_serial_ctrl.sv
// Bit-serial A <= B comparator: one shared cell walks the latched operands LSB first.
// Optional Eq output when RED_SERIAL_EQ_FLAG_EN is defined.
module red_iterativa_serial_ctrl
   import red_iterativa_pkg::*;
#(
   parameter int unsigned N = 3
) (
   input logic                       clk,
   input logic                       rst,
   red_iterativa_serial_ctrl_if.slave bus_io
);
   localparam int unsigned     IdxW     = (N > 1) ? $clog2(N) : 1;
   localparam logic [IdxW-1:0] IDX_LAST = IdxW'(N - 1);

   state_e          state_q, state_d;
   logic [N-1:0]    a_q, a_d, b_q, b_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic            z_q, z_d, zout_q, zout_d;
   logic            z_next, bit_a, bit_b;

   assign bit_a = a_q[idx_q];
   assign bit_b = b_q[idx_q];

   celda_der_izq u_celda (
      .a     (bit_a),
      .b     (bit_b),
      .z_in  (z_q),
      .z_out (z_next)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      z_d     = z_q;
      zout_d  = zout_q;
      unique case (state_q)
         StIdle: begin
            if (bus_io.start) begin
               a_d     = bus_io.A;
               b_d     = bus_io.B;
               idx_d   = '0;
               z_d     = Z_INIT;
               state_d = StRun;
            end
         end
         StRun: begin
            z_d   = z_next;
            idx_d = idx_q + IdxW'(1);
            if (idx_q == IDX_LAST) begin
               zout_d  = z_next;
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         z_q     <= Z_INIT;
         zout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         z_q     <= z_d;
         zout_q  <= zout_d;
      end
   end

   assign bus_io.busy = (state_q == StRun);
   assign bus_io.done = (state_q == StDone);
   assign bus_io.Zout = zout_q;

`ifdef RED_SERIAL_EQ_FLAG_EN
   // Sticky match flag: cleared by the first differing bit pair.
   logic eq_q, eq_d, eqo_q, eqo_d;

   always_comb begin
      eq_d  = eq_q;
      eqo_d = eqo_q;
      if (state_q == StIdle && bus_io.start) begin
         eq_d = 1'b1;
      end else if (state_q == StRun) begin
         eq_d = eq_q & ~(bit_a ^ bit_b);
         if (idx_q == IDX_LAST) eqo_d = eq_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         eq_q  <= 1'b0;
         eqo_q <= 1'b0;
      end else begin
         eq_q  <= eq_d;
         eqo_q <= eqo_d;
      end
   end

   assign bus_io.Eq = eqo_q;
`endif

endmodule
